// File: rtl/param_table_pkg.sv
// Shared constants, reset table and FSM state type for the parameter table loader.
package param_table_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;

  localparam logic [WIDTH-1:0] DEFAULT_TABLE [DEPTH] = '{32'd121, 32'd110, 32'd2, 32'd20};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCommit
  } state_e;

endpackage

// File: rtl/param_table_loader.sv
// Loads DEPTH entries into a shadow table, then publishes them to the committed
// outputs in a single edge so a..d never expose a partial load.
module param_table_loader #(
  parameter int unsigned DEPTH = param_table_pkg::DEPTH,
  parameter int unsigned WIDTH = param_table_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic             err
);

  import param_table_pkg::*;

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  index_q, index_d;
  logic             err_q, err_d;
  logic             accept, commit;
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [WIDTH-1:0] table_q  [DEPTH];

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    err_d    = 1'b0;
    in_ready = 1'b0;
    accept   = 1'b0;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          index_d = '0;
        end
      end
      StLoad: begin
        // Abort beats a coincident final beat, so it also withholds ready.
        in_ready = !abort;
        err_d    = start;
        if (abort) begin
          state_d = StIdle;
          index_d = '0;
        end else if (in_valid) begin
          accept = 1'b1;
          if (index_q == IdxW'(DEPTH - 1)) begin
            commit  = 1'b1;
            state_d = StCommit;
            index_d = '0;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      StCommit: begin
        err_d   = start;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      index_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        shadow_q[i] <= WIDTH'(DEFAULT_TABLE[i]);
        table_q[i]  <= WIDTH'(DEFAULT_TABLE[i]);
      end
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      err_q   <= err_d;
      if (accept) begin
        shadow_q[index_q] <= in_data;
      end
      // The final beat bypasses the shadow so the table lands on the edge entering
      // COMMIT, lining the new values up with the done pulse.
      if (commit) begin
        for (int i = 0; i < DEPTH; i++) begin
          table_q[i] <= (i == DEPTH - 1) ? in_data : shadow_q[i];
        end
      end
    end
  end

  assign a    = table_q[0];
  assign b    = table_q[1];
  assign c    = table_q[2];
  assign d    = table_q[3];
  assign busy = (state_q != StIdle);
  assign done = (state_q == StCommit);
  assign err  = err_q;

endmodule

// File: tb/tb_param_table_loader.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// compared against a beat-queue reference model.
module tb_param_table_loader;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, abort, in_valid;
  logic [W-1:0] in_data;
  logic         in_ready, busy, done, err;
  logic [W-1:0] a, b, c, d;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  param_table_loader #(
    .DEPTH(4),
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Reference model: a load is a queue of collected beats; the table changes only
  // once four beats have arrived without an abort.
  bit           m_loading, m_committing, m_err;
  logic [W-1:0] m_beats[$];
  logic [W-1:0] m_tbl[4];

  function automatic void chk(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_loading    = 1'b0;
    m_committing = 1'b0;
    m_err        = 1'b0;
    m_beats.delete();
    m_tbl = '{32'd121, 32'd110, 32'd2, 32'd20};
  endfunction

  function automatic void model_step(bit r, bit s, bit ab, bit v, logic [W-1:0] dat);
    bit was_busy;
    if (r) begin
      model_reset();
    end else begin
      was_busy = m_loading || m_committing;
      m_err    = s && was_busy;
      if (m_committing) begin
        m_committing = 1'b0;
      end else if (m_loading) begin
        if (ab) begin
          m_loading = 1'b0;
        end else if (v) begin
          m_beats.push_back(dat);
          if (m_beats.size() == 4) begin
            for (int i = 0; i < 4; i++) m_tbl[i] = m_beats[i];
            m_loading    = 1'b0;
            m_committing = 1'b1;
          end
        end
      end else if (s) begin
        m_loading = 1'b1;
        m_beats.delete();
      end
    end
  endfunction

  function automatic void model_check(string tag);
    chk({tag, " busy"}, busy, m_loading || m_committing);
    chk({tag, " done"}, done, m_committing);
    chk({tag, " err"}, err, m_err);
    chk({tag, " in_ready"}, in_ready, m_loading && !abort);
    chk({tag, " a"}, a, m_tbl[0]);
    chk({tag, " b"}, b, m_tbl[1]);
    chk({tag, " c"}, c, m_tbl[2]);
    chk({tag, " d"}, d, m_tbl[3]);
  endfunction

  task automatic drive(bit r, bit s, bit ab, bit v, logic [W-1:0] dat);
    rst      = r;
    start    = s;
    abort    = ab;
    in_valid = v;
    in_data  = dat;
    #1;
  endtask

  task automatic tick(bit r, bit s, bit ab, bit v, logic [W-1:0] dat);
    @(posedge clk);
    model_step(r, s, ab, v, dat);
    #1;
  endtask

  // One cycle, model-checked before the edge.
  task automatic cyc(string tag, bit r, bit s, bit ab, bit v, logic [W-1:0] dat);
    drive(r, s, ab, v, dat);
    model_check(tag);
    tick(r, s, ab, v, dat);
  endtask

  typedef struct {
    logic [2:0]   ctl;    // {start, abort, in_valid}
    logic [W-1:0] data;
    logic [3:0]   flags;  // expected {busy, done, err, in_ready}
    logic [W-1:0] ea, eb, ec, ed;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [2:0] ctl, int dat, logic [3:0] flags,
                              int ea, int eb, int ec, int ed);
    vec_t v;
    v.ctl = ctl; v.data = dat; v.flags = flags;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("reset a", a, 121);
    chk("reset b", b, 110);
    chk("reset c", c, 2);
    chk("reset d", d, 20);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset in_ready", in_ready, 0);

    // Full load, start-in-LOAD error, back-to-back start, abort on final beat
    add(3'b100, 0, 4'b0000, 121, 110, 2, 20);
    add(3'b001, 5, 4'b1001, 121, 110, 2, 20);
    add(3'b001, 6, 4'b1001, 121, 110, 2, 20);
    add(3'b001, 7, 4'b1001, 121, 110, 2, 20);
    add(3'b001, 8, 4'b1001, 121, 110, 2, 20);
    add(3'b000, 0, 4'b1100, 5, 6, 7, 8);
    add(3'b000, 0, 4'b0000, 5, 6, 7, 8);
    add(3'b100, 0, 4'b0000, 5, 6, 7, 8);
    add(3'b001, 1, 4'b1001, 5, 6, 7, 8);
    add(3'b001, 2, 4'b1001, 5, 6, 7, 8);
    add(3'b100, 0, 4'b1001, 5, 6, 7, 8);
    add(3'b001, 3, 4'b1011, 5, 6, 7, 8);
    add(3'b001, 4, 4'b1001, 5, 6, 7, 8);
    add(3'b000, 0, 4'b1100, 1, 2, 3, 4);
    add(3'b100, 0, 4'b0000, 1, 2, 3, 4);
    add(3'b001, 9, 4'b1001, 1, 2, 3, 4);
    add(3'b001, 9, 4'b1001, 1, 2, 3, 4);
    add(3'b001, 9, 4'b1001, 1, 2, 3, 4);
    add(3'b011, 9, 4'b1000, 1, 2, 3, 4);
    add(3'b000, 0, 4'b0000, 1, 2, 3, 4);
    add(3'b000, 0, 4'b0000, 1, 2, 3, 4);

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(1'b0, vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].data);
      chk({t, " busy"}, busy, vecs[i].flags[3]);
      chk({t, " done"}, done, vecs[i].flags[2]);
      chk({t, " err"}, err, vecs[i].flags[1]);
      chk({t, " in_ready"}, in_ready, vecs[i].flags[0]);
      chk({t, " a"}, a, vecs[i].ea);
      chk({t, " b"}, b, vecs[i].eb);
      chk({t, " c"}, c, vecs[i].ec);
      chk({t, " d"}, d, vecs[i].ed);
      tick(1'b0, vecs[i].ctl[2], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].data);
    end

    // Gappy load then abort: busy drops, table keeps reset values, no done
    cyc("rst34", 1'b1, 1'b0, 1'b0, 1'b0, '0);
    cyc("abt", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc("abt", 1'b0, 1'b0, 1'b0, 1'b1, 1);
    cyc("abt", 1'b0, 1'b0, 1'b0, 1'b0, 77);
    cyc("abt", 1'b0, 1'b0, 1'b0, 1'b1, 2);
    cyc("abt", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    cyc("abt", 1'b0, 1'b0, 1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort a", a, 121);
    chk("abort d", d, 20);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Reset mid-load, then a complete load must still work
    cyc("rl", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc("rl", 1'b0, 1'b0, 1'b0, 1'b1, 9);
    cyc("rl", 1'b0, 1'b0, 1'b0, 1'b1, 9);
    cyc("rl", 1'b0, 1'b0, 1'b0, 1'b1, 9);
    cyc("rl", 1'b1, 1'b0, 1'b0, 1'b1, 9);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("rstmid busy", busy, 0);
    chk("rstmid in_ready", in_ready, 0);
    chk("rstmid a", a, 121);
    chk("rstmid c", c, 2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc("rl2", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc("rl2", 1'b0, 1'b0, 1'b0, 1'b1, 10);
    cyc("rl2", 1'b0, 1'b0, 1'b0, 1'b1, 20);
    cyc("rl2", 1'b0, 1'b0, 1'b0, 1'b1, 30);
    cyc("rl2", 1'b0, 1'b0, 1'b0, 1'b1, 40);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4 && !done; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("reload done", done, 1);
    chk("reload a", a, 10);
    chk("reload b", b, 20);
    chk("reload c", c, 30);
    chk("reload d", d, 40);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, s, ab, v;
      r  = ($urandom_range(0, 63) == 0);
      s  = ($urandom_range(0, 7) == 0);
      ab = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 1) == 1);
      cyc("rand", r, s, ab, v, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_table_loader.md
PARAM_TABLE_LOADER -- requirements
Module: param_table_loader

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of table entries (fixed 4; outputs a..d map to entries 0..3).
REQ-002 SHALL have parameter: WIDTH, 32, entry width in bits.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: start  input  1  request to begin a load sequence.
REQ-006 SHALL have port: abort  input  1  discard an in-progress load.
REQ-007 SHALL have port: in_valid  input  1  in_data holds a beat.
REQ-008 SHALL have port: in_data  input  WIDTH  entry value, written in index order 0..DEPTH-1.
REQ-009 SHALL have port: in_ready  output  1  block accepts a beat this cycle.
REQ-010 SHALL have ports: a, b, c, d  output  WIDTH each  committed table entries 0, 1, 2, 3.
REQ-011 SHALL have port: busy  output  1  load sequence in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on commit.
REQ-013 SHALL have port: err  output  1  one-cycle pulse on protocol violation.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, COMMIT.
REQ-015 SHALL move IDLE->LOAD when start=1; index counter cleared to 0 on that edge.
REQ-016 SHALL assert in_ready=1 only in LOAD; a beat is accepted when in_valid && in_ready.
REQ-017 SHALL write each accepted beat into shadow[index], then increment index; beats with in_valid=0 cause no change.
REQ-018 SHALL move LOAD->COMMIT on acceptance of the beat at index DEPTH-1; index never exceeds DEPTH-1.
REQ-019 SHALL, in COMMIT, copy all shadow entries into the committed table atomically (one edge), assert done for that single cycle, return to IDLE.
REQ-020 SHALL drive a..d from committed registers only; they never show partial loads.
REQ-021 SHALL assert busy in LOAD and COMMIT; busy=0 in IDLE.
REQ-022 SHALL, on abort=1 in LOAD, return to IDLE next cycle, leave committed table unchanged, no done; abort wins over a simultaneous final beat.
REQ-023 SHALL ignore abort in IDLE and COMMIT (commit completes).
REQ-024 SHALL, on start=1 while in LOAD or COMMIT, ignore it and pulse err next cycle; state and index unaffected.
REQ-025 SHALL allow start in the cycle after done (IDLE) to begin a new load immediately.
REQ-026 SHALL have latency: done asserted one cycle after the last beat is accepted; a..d update on the same edge done rises.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, set state=IDLE, index=0, in_ready=0, busy=0, done=0, err=0.
REQ-028 SHALL reset committed table to DEFAULT_TABLE = {121, 110, 2, 20} (a=121, b=110, c=2, d=20); shadow reset to the same.
REQ-029 SHALL have rst override all other inputs, including mid-LOAD and during COMMIT (no commit occurs).

Structure
REQ-030 SHALL place DEPTH, WIDTH, DEFAULT_TABLE (unpacked array parameter) and state enum in shared package param_table_pkg.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 SHALL verify: reset only -> a=121, b=110, c=2, d=20, busy=0, done=0.
REQ-033 SHALL verify: start, beats 5,6,7,8 back-to-back -> done pulse one cycle after beat 8; a=5, b=6, c=7, d=8; a..d held at reset values until then.
REQ-034 SHALL verify: start, beats 1,2 with in_valid gaps, abort -> busy falls next cycle, a..d remain 121,110,2,20, no done.
REQ-035 SHALL verify: start in LOAD after 2 beats -> single err pulse; load continues, beats 3,4 complete with a..d = 1,2,3,4.
REQ-036 SHALL verify: rst asserted after 3 beats of {9,9,9,_} -> a..d = 121,110,2,20, state IDLE, subsequent full load works.
REQ-037 SHALL verify: abort coincident with 4th beat -> no commit, no done, table unchanged.
